// File: rtl/ir_encode_loader_pkg.sv
// Shared RV32I field types and loader state encoding for the instruction encoder/loader.
package ir_encode_loader_pkg;

    typedef logic [6:0] rv32i_opcode;
    typedef logic [4:0] rv32i_reg;

    // Instruction formats accepted by the encoder; codes 6 and 7 are undefined.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } ld_state_t;

    // True when imm[31:lsb] are all ones or all zeros, i.e. the value is a proper
    // sign extension of its low bits and the field can be truncated without loss.
    function automatic logic upper_uniform(input logic [31:0] imm, input logic [4:0] lsb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << lsb;
        return ((imm & mask) == mask) || ((imm & mask) == 32'h0);
    endfunction

endpackage

// File: rtl/ir_encode.sv
// Combinational RV32I field packer: builds the 32-bit instruction word and flags
// immediates that do not fit the chosen format (the word is still produced, truncated).
module ir_encode
    import ir_encode_loader_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  rv32i_opcode i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  rv32i_reg    i_rs1,
    input  rv32i_reg    i_rs2,
    input  rv32i_reg    i_rd,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_fault
);

    // Pack fields by format and check immediate range/alignment.
    always_comb begin
        o_word  = 32'h0;
        o_fault = 1'b0;
        case (instr_fmt_t'(i_fmt))
            FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I: begin
                o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_fault = !upper_uniform(i_imm, 5'd11);
            end
            FMT_S: begin
                o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_fault = !upper_uniform(i_imm, 5'd11);
            end
            FMT_B: begin
                o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
                o_fault = !upper_uniform(i_imm, 5'd12) || i_imm[0];
            end
            FMT_U: begin
                o_word  = {i_imm[31:12], i_rd, i_opcode};
                o_fault = |i_imm[11:0];
            end
            FMT_J: begin
                o_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_fault = !upper_uniform(i_imm, 5'd20) || i_imm[0];
            end
            default: begin
                o_word  = 32'h0;
                o_fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ir_encode_loader.sv
// Streams encoded RV32I instructions into instruction memory, one word per
// valid/ready bundle, starting at BASE_ADDR and stopping on in_last or overflow.
module ir_encode_loader
    import ir_encode_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_imm,
    input  logic             in_last,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byte_enable,
    input  logic             mem_resp,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] word_count
);

    ld_state_t        r_state;
    logic             r_in_ready;
    logic             r_mem_write;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_last;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      w_word;
    logic             w_fault;
    logic [CNT_W-1:0] w_cnt_next;

    ir_encode u_encode (
        .i_fmt    (in_fmt),
        .i_opcode (in_opcode),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_rd     (in_rd),
        .i_imm    (in_imm),
        .o_word   (w_word),
        .o_fault  (w_fault)
    );

    assign w_cnt_next = r_count + CNT_W'(1);

    // Loader FSM with all outputs registered; reset drops any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_wdata     <= 32'h0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_ACCEPT;
                        r_error    <= 1'b0;
                        r_count    <= '0;
                        r_addr     <= BASE_ADDR;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        r_wdata     <= w_word;
                        r_last      <= in_last;
                        r_in_ready  <= 1'b0;
                        r_mem_write <= 1'b1;
                        r_state     <= ST_WRITE;
                        if (w_fault) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_resp) begin
                        r_mem_write <= 1'b0;
                        r_addr      <= r_addr + 32'd4;
                        r_count     <= w_cnt_next;
                        if (r_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (w_cnt_next == CNT_W'(MAX_WORDS)) begin
                            // Buffer full with no terminating bundle: abort the load.
                            r_error <= 1'b1;
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_ACCEPT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = r_in_ready;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_byte_enable = r_mem_write ? 4'hF : 4'h0;
    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign word_count      = r_count;

endmodule

// File: tb/tb_ir_encode_loader.sv
// Directed bench for ir_encode_loader: hand-encoded vectors, delayed responses,
// overflow with a 4-word limit and reset during a write.
module tb_ir_encode_loader;

    localparam int CNT_W = 9;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [6:0]       in_opcode;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [4:0]       in_rd;
    logic [31:0]      in_imm;
    logic             in_last;
    logic             mem_write;
    logic [31:0]      mem_address;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_byte_enable;
    logic             mem_resp;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] word_count;

    int n_chk;
    int n_fail;
    int done_cnt;

    ir_encode_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_fmt          (in_fmt),
        .in_opcode       (in_opcode),
        .in_funct3       (in_funct3),
        .in_funct7       (in_funct7),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_rd           (in_rd),
        .in_imm          (in_imm),
        .in_last         (in_last),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .word_count      (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses as seen at the sampling edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one bundle and hold it until the handshake completes.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] imm, input logic last);
        int n;
        in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("handshake_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for a write, check it stays stable for `delay` cycles, then respond.
    task automatic do_write(input string tag, input int delay,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data);
        int n;
        n = 0;
        while (!mem_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({tag, "_wait"}, 32'd0, 32'd1);
        check({tag, "_addr"}, mem_address, exp_addr);
        check({tag, "_data"}, mem_wdata, exp_data);
        check({tag, "_be"}, {28'h0, mem_byte_enable}, 32'hF);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {mem_write, mem_address[30:0]}, {1'b1, exp_addr[30:0]});
        end
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
    endtask

    initial begin
        int base;
        n_chk = 0; n_fail = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_resp = 1'b0;
        in_fmt = 3'd0; in_opcode = 7'h0; in_funct3 = 3'h0; in_funct7 = 7'h0;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_imm = 32'h0; in_last = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", {27'h0, busy, done, error, mem_write, in_ready}, 32'h0);
        check("rst_addr", mem_address, 32'h0);
        check("rst_cnt", {23'h0, word_count}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // R: add x3,x1,x2
        do_start();
        check("start_busy_rdy", {30'h0, busy, in_ready}, 32'h3);
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1);
        check("r_latency", {31'h0, mem_write}, 32'h1);
        do_write("r_add", 1, 32'h0, 32'h0020_81B3);
        check("r_done", {29'h0, done, error, mem_write}, 32'h4);
        check("r_cnt", {23'h0, word_count}, 32'h1);
        @(negedge clk);
        check("r_idle", {30'h0, busy, done}, 32'h0);

        // I: addi x1,x0,-1
        do_start();
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 1'b1);
        do_write("i_neg", 1, 32'h0, 32'hFFF0_0093);
        check("i_neg_err", {30'h0, done, error}, 32'h2);

        // I: imm 0x800 out of range, still written
        do_start();
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800, 1'b1);
        check("i_ovf_err_early", {31'h0, error}, 32'h1);
        do_write("i_ovf", 1, 32'h0, 32'h8000_0093);
        check("i_ovf_err", {30'h0, done, error}, 32'h3);

        // B: imm -4, then misaligned imm 3
        do_start();
        check("err_cleared", {31'h0, error}, 32'h0);
        send(3'd3, 7'h63, 3'd1, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b1);
        do_write("b_neg", 1, 32'h0, 32'hFE20_9EE3);
        check("b_neg_err", {31'h0, error}, 32'h0);
        do_start();
        send(3'd3, 7'h63, 3'd1, 7'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0003, 1'b1);
        do_write("b_odd", 1, 32'h0, 32'h0020_9163);
        check("b_odd_err", {31'h0, error}, 32'h1);

        // U: lui x5,0x12345 (clean) then undefined format (word 0, error)
        do_start();
        send(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 1'b1);
        do_write("u_lui", 1, 32'h0, 32'h1234_52B7);
        check("u_lui_err", {31'h0, error}, 32'h0);
        do_start();
        send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1);
        do_write("bad_fmt", 1, 32'h0, 32'h0);
        check("bad_fmt_err", {31'h0, error}, 32'h1);

        // 3-word load with slow memory
        @(negedge clk);
        base = done_cnt;
        do_start();
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1, 1'b0);
        do_write("ld3_w0", 5, 32'h0, 32'h0010_0093);
        check("ld3_cnt0", {23'h0, word_count}, 32'h1);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'd2, 1'b0);
        do_write("ld3_w1", 5, 32'h4, 32'h0020_0113);
        check("ld3_cnt1", {23'h0, word_count}, 32'h2);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd3, 1'b1);
        do_write("ld3_w2", 5, 32'h8, 32'h0030_0193);
        check("ld3_cnt2", {23'h0, word_count}, 32'h3);
        repeat (4) @(negedge clk);
        check("ld3_done_pulses", done_cnt - base, 32'd1);

        // Overflow: 4-word limit, no in_last
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
            do_write("ovf_w", 1, 32'(i * 4), 32'h0020_81B3);
        end
        check("ovf_state", {29'h0, done, error, in_ready}, 32'h6);
        check("ovf_cnt", {23'h0, word_count}, 32'h4);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("ovf_5th_blocked", {29'h0, in_ready, mem_write, busy}, 32'h0);
        in_valid = 1'b0;

        // Reset in the middle of the second write
        do_start();
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        do_write("mid_w0", 1, 32'h0, 32'h0020_81B3);
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        check("mid_pre", {22'h0, mem_write, word_count}, 32'h201);
        rst_n = 1'b0;
        #1;
        check("mid_rst", {22'h0, mem_write, busy, word_count[7:0]}, 32'h0);
        check("mid_rst_addr", mem_address, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1);
        do_write("restart", 1, 32'h0, 32'h0020_81B3);
        check("restart_done", {22'h0, done, word_count}, 32'h201);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
